imem_loader: RTL

- Writer side of the instruction memory: a boot-time program loader.
- Accepts a byte stream on a valid/ready interface and assembles little-endian 32-bit instruction words.
- Drives a synchronous write port of a writable instruction memory at consecutive word addresses.
- Holds the CPU in reset until the program image has been fully written.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_byte_assembler.sv | 59 +++++
 rtl/imem_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the boot-time instruction memory loader.
//   - loader_state_t : loader FSM states (CSUM only exists when the
//                      IMEM_LOADER_CHECKSUM_EN macro is defined)
//   - LEN_BYTES, WORD_BYTES, CSUM_BYTES : field sizes in the byte stream
//   - addr_bits()    : word-index width for a given memory depth
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        CSUM  = 3'd6
`endif
    } loader_state_t;

    function automatic int addr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_byte_assembler.sv
// ---------------------------------------------------------------------------
// imem_byte_assembler
// Collects 8-bit stream bytes into a little-endian 32-bit word.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   i_clear        : drop any partially assembled word
//   i_take         : a byte handshake happens this cycle
//   i_byte         : the byte being taken
//   i_last_idx     : index of the byte that completes the current field
//                    (1 for a 2-byte field, 3 for a 4-byte field)
//   o_word_valid   : field completes this cycle (combinational)
//   o_word         : assembled field including the incoming byte
// ---------------------------------------------------------------------------
module imem_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_take,
    input  logic [7:0]  i_byte,
    input  logic [1:0]  i_last_idx,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_count;
    logic [31:0] r_shift;
    logic [31:0] w_word;

    // The incoming byte is merged in combinationally so the owner can latch
    // the complete word on the same edge as the final handshake.
    always_comb begin
        w_word = r_shift;
        case (r_count)
            2'd0:    w_word[7:0]   = i_byte;
            2'd1:    w_word[15:8]  = i_byte;
            2'd2:    w_word[23:16] = i_byte;
            default: w_word[31:24] = i_byte;
        endcase
    end

    assign o_word       = w_word;
    assign o_word_valid = i_take && (r_count == i_last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_shift <= 32'd0;
        end else if (i_clear || o_word_valid) begin
            r_count <= 2'd0;
            r_shift <= 32'd0;
        end else if (i_take) begin
            r_count <= r_count + 2'd1;
            r_shift <= w_word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time program loader: takes a byte stream (2-byte LE word count N,
// then N LE 32-bit words), writes the words to consecutive addresses of the
// instruction memory and holds the CPU in reset until the image is in place.
// Optional macro IMEM_LOADER_CHECKSUM_EN: a 4-byte LE trailer equal to the
// mod-2^32 sum of all words must follow; mismatch aborts with error.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_start       : one-cycle load request (ignored while busy)
//   i_rx_valid    : byte available on i_rx_data
//   i_rx_data     : stream byte
//   o_rx_ready    : byte accepted when i_rx_valid & o_rx_ready
//   o_mem_we      : one-cycle write pulse per word
//   o_mem_addr    : byte address of the write
//   o_mem_wdata   : word to write
//   o_cpu_rst     : CPU reset hold
//   o_busy        : load in progress
//   o_done        : load completed (sticky until next start/rst)
//   o_error       : load aborted (sticky until next start/rst)
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_rx_valid,
    input  logic [7:0]       i_rx_data,
    output logic             o_rx_ready,
    output logic             o_mem_we,
    output logic [31:0]      o_mem_addr,
    output logic [WIDTH-1:0] o_mem_wdata,
    output logic             o_cpu_rst,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
);

    localparam int                  ADDR_BITS   = addr_bits(DEPTH);
    localparam logic [16:0]         DEPTH_LIMIT = 17'(DEPTH);
    localparam logic [ADDR_BITS:0]  CNT_ONE     = (ADDR_BITS+1)'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t PAYLOAD_END = CSUM;
`else
    localparam loader_state_t PAYLOAD_END = DONE;
`endif

    loader_state_t      r_state;
    loader_state_t      w_next;
    logic [15:0]        r_len;
    logic               r_lenLatched;
    logic [ADDR_BITS:0] r_wordCnt;
    logic [31:0]        r_addr;
    logic [WIDTH-1:0]   r_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]        r_sum;
`endif

    logic               w_take;
    logic               w_startAccept;
    logic               w_wordValid;
    logic [31:0]        w_word;
    logic [1:0]         w_lastIdx;
    logic               w_lastWord;

    imem_byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_startAccept),
        .i_take       (w_take),
        .i_byte       (i_rx_data),
        .i_last_idx   (w_lastIdx),
        .o_word_valid (w_wordValid),
        .o_word       (w_word)
    );

    // Ready and field size depend on state only, kept apart from the
    // next-state logic so the handshake path has no loop through it.
    // Once the length is latched, LEN stops accepting for one cycle while
    // the count is checked.
    always_comb begin
        o_rx_ready = 1'b0;
        w_lastIdx  = 2'(WORD_BYTES - 1);
        case (r_state)
            LEN: begin
                o_rx_ready = !r_lenLatched;
                w_lastIdx  = 2'(LEN_BYTES - 1);
            end
            DATA: o_rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                o_rx_ready = 1'b1;
                w_lastIdx  = 2'(CSUM_BYTES - 1);
            end
`endif
            default: o_rx_ready = 1'b0;
        endcase
    end

    assign w_take        = i_rx_valid && o_rx_ready;
    assign w_startAccept = i_start && (r_state == IDLE || r_state == DONE || r_state == ERR);
    assign w_lastWord    = (r_wordCnt + CNT_ONE) == r_len[ADDR_BITS:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        o_mem_we  = 1'b0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        o_error   = 1'b0;
        o_cpu_rst = 1'b1;
        case (r_state)
            IDLE: begin
                if (i_start) w_next = LEN;
            end
            LEN: begin
                o_busy = 1'b1;
                if (r_lenLatched) begin
                    if (r_len == 16'd0)                   w_next = PAYLOAD_END;
                    else if ({1'b0, r_len} > DEPTH_LIMIT) w_next = ERR;
                    else                                  w_next = DATA;
                end
            end
            DATA: begin
                o_busy = 1'b1;
                if (w_wordValid) w_next = WRITE;
            end
            WRITE: begin
                o_busy   = 1'b1;
                o_mem_we = 1'b1;
                w_next   = w_lastWord ? PAYLOAD_END : DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                o_busy = 1'b1;
                if (w_wordValid) w_next = (w_word == r_sum) ? DONE : ERR;
            end
`endif
            DONE: begin
                o_done    = 1'b1;
                o_cpu_rst = 1'b0;
                if (i_start) w_next = LEN;
            end
            ERR: begin
                o_error = 1'b1;
                if (i_start) w_next = LEN;
            end
            default: w_next = IDLE;
        endcase
    end

    // Length, word data, address and running sum. r_addr always holds the
    // address of the word about to be written, so mem_addr needs no adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len        <= 16'd0;
            r_lenLatched <= 1'b0;
            r_wordCnt    <= '0;
            r_addr       <= BASE_ADDR;
            r_wdata      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum        <= 32'd0;
`endif
        end else begin
            if (w_startAccept) begin
                r_lenLatched <= 1'b0;
                r_wordCnt    <= '0;
                r_addr       <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_sum        <= 32'd0;
`endif
            end
            if (r_state == LEN && w_wordValid) begin
                r_len        <= w_word[15:0];
                r_lenLatched <= 1'b1;
            end
            if (r_state == DATA && w_wordValid) begin
                r_wdata <= w_word[WIDTH-1:0];
            end
            if (r_state == WRITE) begin
                r_wordCnt <= r_wordCnt + CNT_ONE;
                r_addr    <= r_addr + 32'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_sum     <= r_sum + r_wdata;
`endif
            end
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

endmodule
